// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and sizing constants for the data-memory responder.
package dmem_pkg;

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LANE_W    = 8;
  localparam int unsigned WORD_W    = NUM_LANES * LANE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Request payload captured at acceptance.
  typedef struct packed {
    logic                 we;
    logic [WORD_W-1:0]    wdata;
    logic [NUM_LANES-1:0] be;
  } req_t;

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: synchronous word array with per-byte write enables and a
// registered read port that clears on reset and holds between reads.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [WORD_W-1:0]     wdata,
  input  logic [NUM_LANES-1:0]  be,
  output logic [WORD_W-1:0]     rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WORD_W-1:0] mem [DEPTH];

  // Byte-lane write; a reset on the same edge blocks the commit.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        if (be[i]) begin
          mem[idx][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Read register: loads only on a read response, otherwise holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: req/ack data-memory target with LATENCY wait states.
// Optional feature macro: DMEM_MISALIGN_ERR_EN (misaligned requests ack with
// err=1 and have no effect on memory or rdata).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam bit              HAS_WAIT = (LATENCY != 0);
  localparam logic [CNT_W-1:0] CNT_LOAD = HAS_WAIT ? CNT_W'(LATENCY - 1) : '0;

  state_e                  state;
  state_e                  state_nxt;
  logic [CNT_W-1:0]        cnt;
  req_t                    req_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic                    misalign_q;

  logic                    accept;
  logic                    commit;
  logic                    cur_we;
  logic                    cur_mis;
  logic [DEPTH_LOG2-1:0]   cur_idx;
  logic [WORD_W-1:0]       cur_wdata;
  logic [NUM_LANES-1:0]    cur_be;
  logic                    wr_en;
  logic                    rd_en;
  logic                    addr_mis;

`ifdef DMEM_MISALIGN_ERR_EN
  assign addr_mis = (addr[1:0] != 2'b00);
  logic unused_addr;
  assign unused_addr = ^addr[31:DEPTH_LOG2+2];
`else
  assign addr_mis = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; RESP always returns to IDLE regardless of req.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = HAS_WAIT ? WAIT : RESP;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control decode; in IDLE the live request feeds the zero-latency commit.
  always_comb begin
    accept    = 1'b0;
    commit    = 1'b0;
    cur_we    = req_q.we;
    cur_idx   = idx_q;
    cur_wdata = req_q.wdata;
    cur_be    = req_q.be;
    cur_mis   = misalign_q;
    case (state)
      IDLE: begin
        accept    = req;
        commit    = req && !HAS_WAIT;
        cur_we    = we;
        cur_idx   = addr[DEPTH_LOG2+1:2];
        cur_wdata = wdata;
        cur_be    = be;
        cur_mis   = addr_mis;
      end
      WAIT:    commit = (cnt == '0);
      default: ;
    endcase
  end

  assign wr_en = commit && cur_we && !cur_mis;
  assign rd_en = commit && !cur_we && !cur_mis;

  // Wait-state counter: loaded at acceptance, counts down to zero in WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_LOAD;
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Request capture; fields are frozen from acceptance until the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q      <= '0;
      idx_q      <= '0;
      misalign_q <= 1'b0;
    end else if (accept) begin
      req_q.we    <= we;
      req_q.wdata <= wdata;
      req_q.be    <= be;
      idx_q       <= addr[DEPTH_LOG2+1:2];
      misalign_q  <= addr_mis;
    end
  end

  // Response pulse, coincident with the RESP cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack <= 1'b0;
    end else begin
      ack <= commit;
    end
  end

`ifdef DMEM_MISALIGN_ERR_EN
  // Error qualifier, high only alongside ack for a misaligned request.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= commit && cur_mis;
    end
  end
`else
  assign err = 1'b0;
`endif

  dmem_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .idx   (cur_idx),
    .wdata (cur_wdata),
    .be    (cur_be),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: two responders (LATENCY=2 and LATENCY=0) checked every
// cycle against a timestamp-based transaction model, plus directed literals.
module tb_dmem_responder;

  localparam int LAT_A = 2;
  localparam int LAT_B = 0;

  logic        clk;
  logic        reset [2];
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic        ack   [2];
  logic [31:0] rdata [2];
  logic        err   [2];

  int n_cmp = 0;
  int n_mis = 0;

  dmem_responder #(.DEPTH_LOG2(6), .LATENCY(LAT_A)) u_dut_a (
    .clk(clk), .reset(reset[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .be(be[0]), .ack(ack[0]), .rdata(rdata[0]), .err(err[0])
  );

  dmem_responder #(.DEPTH_LOG2(6), .LATENCY(LAT_B)) u_dut_b (
    .clk(clk), .reset(reset[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .be(be[1]), .ack(ack[1]), .rdata(rdata[1]), .err(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT_A : LAT_B;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Each request gets a due cycle = accept cycle + 1 + LATENCY; the unit is
  // busy until its due cycle, and memory effects land when the due cycle starts.
  logic [31:0] mem_m [2][64];
  logic [3:0]  kn_m  [2][64];
  int          due   [2];
  int          cyc;
  logic        c_we    [2];
  logic [31:0] c_addr  [2];
  logic [31:0] c_wdata [2];
  logic [3:0]  c_be    [2];
  logic        e_ack   [2];
  logic        e_err   [2];
  logic [31:0] e_rd    [2];
  logic        e_rd_kn [2];
  logic        live    [2];

  initial begin
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      due[k] = -1; live[k] = 1'b0; e_ack[k] = 1'b0; e_err[k] = 1'b0;
      e_rd[k] = '0; e_rd_kn[k] = 1'b0;
      for (int w = 0; w < 64; w++) kn_m[k][w] = 4'h0;
    end
  end

  always @(posedge clk) begin : model
    int  idx;
    logic mis;
    for (int k = 0; k < 2; k++) begin
      if (reset[k]) begin
        due[k] = -1; e_ack[k] = 1'b0; e_err[k] = 1'b0;
        e_rd[k] = '0; e_rd_kn[k] = 1'b1; live[k] = 1'b1;
      end else begin
        if (req[k] && due[k] < cyc) begin
          due[k] = cyc + 1 + lat_of(k);
          c_we[k] = we[k]; c_addr[k] = addr[k]; c_wdata[k] = wdata[k]; c_be[k] = be[k];
        end
        e_ack[k] = (due[k] == cyc + 1);
        e_err[k] = 1'b0;
        if (e_ack[k]) begin
          idx = int'(c_addr[k][7:2]);
`ifdef DMEM_MISALIGN_ERR_EN
          mis = (c_addr[k][1:0] != 2'b00);
`else
          mis = 1'b0;
`endif
          if (mis) begin
            e_err[k] = 1'b1;
          end else if (c_we[k]) begin
            for (int i = 0; i < 4; i++) begin
              if (c_be[k][i]) begin
                mem_m[k][idx][8*i +: 8] = c_wdata[k][8*i +: 8];
                kn_m[k][idx][i] = 1'b1;
              end
            end
          end else begin
            e_rd[k] = mem_m[k][idx];
            e_rd_kn[k] = (kn_m[k][idx] == 4'hF);
          end
        end
      end
    end
    cyc++;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (live[k]) begin
        check($sformatf("ack%0d", k), 32'(ack[k]), 32'(e_ack[k]));
        check($sformatf("err%0d", k), 32'(err[k]), 32'(e_err[k]));
        if (e_rd_kn[k]) check($sformatf("rdata%0d", k), rdata[k], e_rd[k]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Called at a negedge of an idle cycle; returns at the negedge of the
  // following idle cycle. lat counts cycles from acceptance to ack.
  task automatic txn(input int k, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b,
                     output int lat, output logic [31:0] rd, output logic er);
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack[k] && lat < 40);
    check($sformatf("ack_seen%0d", k), 32'(ack[k]), 32'd1);
    rd = rdata[k];
    er = err[k];
    req[k] = 1'b0;
    @(negedge clk);
  endtask

  initial begin : stim
    int          lat;
    logic [31:0] rd;
    logic        er;

    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0;
      addr[k] = '0; wdata[k] = '0; be[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_ack%0d", k), 32'(ack[k]), 32'd0);
      check($sformatf("rst_rdata%0d", k), rdata[k], 32'd0);
      check($sformatf("rst_err%0d", k), 32'(err[k]), 32'd0);
      reset[k] = 1'b0;
    end
    @(negedge clk);

    // Full-word write/read with LATENCY=2.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er);
    check("wr_lat", 32'(lat), 32'd3);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    check("rd_lat", 32'(lat), 32'd3);
    check("rd_data", rd, 32'hDEADBEEF);
    check("rd_err", 32'(er), 32'd0);

    // Byte-lane merge, then a be=0 write that must still ack.
    txn(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, lat, rd, er);
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er);
    check("lane_data", rd, 32'hDE22BE44);
    txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, lat, rd, er);
    check("be0_lat", 32'(lat), 32'd3);
    check("be0_rdata_hold", rd, 32'hDE22BE44);
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er);
    check("be0_data", rd, 32'hDE22BE44);

    // LATENCY=0: preload, then reads of 0x0 and 0x4 with req held high.
    txn(1, 1'b1, 32'h0, 32'h00001111, 4'hF, lat, rd, er);
    check("l0_wr_lat", 32'(lat), 32'd1);
    txn(1, 1'b1, 32'h4, 32'h00002222, 4'hF, lat, rd, er);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0; be[1] = 4'hF;
    @(negedge clk);
    check("b2b_ack0", 32'(ack[1]), 32'd1);
    check("b2b_data0", rdata[1], 32'h00001111);
    addr[1] = 32'h4;
    @(negedge clk);
    check("b2b_gap", 32'(ack[1]), 32'd0);
    @(negedge clk);
    check("b2b_ack1", 32'(ack[1]), 32'd1);
    check("b2b_data1", rdata[1], 32'h00002222);
    req[1] = 1'b0;
    @(negedge clk);

    // Reset on the commit edge of a write aborts it with no ack.
    txn(0, 1'b1, 32'h20, 32'h12345678, 4'hF, lat, rd, er);
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hCAFEF00D; be[0] = 4'hF;
    @(negedge clk);
    @(negedge clk);
    reset[0] = 1'b1; req[0] = 1'b0;
    @(negedge clk);
    check("abort_ack", 32'(ack[0]), 32'd0);
    check("abort_rdata", rdata[0], 32'd0);
    check("abort_err", 32'(err[0]), 32'd0);
    reset[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_idle", 32'(ack[0]), 32'd0);
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, lat, rd, er);
    check("abort_prior", rd, 32'h12345678);

    // Misaligned write to 0x22.
    txn(0, 1'b1, 32'h22, 32'hA5A5A5A5, 4'hF, lat, rd, er);
    check("mis_lat", 32'(lat), 32'd3);
`ifdef DMEM_MISALIGN_ERR_EN
    check("mis_err", 32'(er), 32'd1);
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, lat, rd, er);
    check("mis_keep", rd, 32'h12345678);
    check("mis_rd_err", 32'(er), 32'd0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er);
    txn(0, 1'b0, 32'h21, 32'h0, 4'hF, lat, rd, er);
    check("mis_rd_err1", 32'(er), 32'd1);
    check("mis_rd_hold", rd, 32'hDE22BE44);
`else
    check("mis_err", 32'(er), 32'd0);
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, lat, rd, er);
    check("mis_land", rd, 32'hA5A5A5A5);
`endif

    // Aliasing: 0x100 maps onto word 0 with 64 words.
    txn(1, 1'b1, 32'h100, 32'h00000001, 4'hF, lat, rd, er);
    txn(1, 1'b0, 32'h0, 32'h0, 4'hF, lat, rd, er);
    check("alias", rd, 32'h00000001);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
